pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register for the MIPS pipeline (F/D, D/E, E/M, M/W). It carries NCH payload channels of W bits each (PC, IR, rs, rt, EXT, ...), plus a valid bit and a branch-delay flag. It supports stall (hold) and flush (bubble insertion with optional PC preservation for EPC). Saturating stall and bubble counters feed the hazard-debug path.

Parameters:
NCH, 5, number of payload channels (min 2)
W, 32, width of each channel in bits
PC_IDX, 0, channel index holding the PC
IR_IDX, 1, channel index holding the instruction word
KEEP_PC_ON_FLUSH, 1, 1 = bubble keeps incoming PC on PC channel; 0 = bubble zeroes it
CNT_W, 16, width of the stall and bubble counters

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream stage holds a real instruction
in_data  in  NCH*W  payload; channel k = bits [k*W +: W]
in_bd  in  1  upstream instruction sits in a delay slot
stall  in  1  hold current contents
flush  in  1  replace next contents with a bubble
cnt_clr  in  1  synchronous clear of both counters
out_valid  out  1  registered valid
out_data  out  NCH*W  registered payload
out_bd  out  1  registered delay-slot flag
stall_cnt  out  CNT_W  cycles in which a stall held a valid entry (saturating)
bubble_cnt  out  CNT_W  bubbles inserted (saturating)

Behaviour:
- Reset: clk and rst_n only; reset is asynchronous and active-low. While rst_n=0, every output is 0: out_valid, out_data, out_bd, stall_cnt and bubble_cnt.
- Priority on each rising edge: flush > stall > load.
- Load (flush=0, stall=0): out_data<=in_data, out_valid<=in_valid, out_bd<=in_bd. Latency is 1 cycle.
- Stall (flush=0, stall=1): all payload, valid and bd are held unchanged. If out_valid=1, stall_cnt increments.
- Flush (flush=1, stall is don't-care): every channel becomes 0, so IR becomes 0 = NOP (sll $0,$0,0). out_valid<=0.
  - Exception: when KEEP_PC_ON_FLUSH=1, channel PC_IDX <= in_data PC channel and out_bd <= in_bd. Otherwise both become 0.
  - bubble_cnt increments.
- Flush during stall: the flush wins. This is the D/E case, where D is held and E receives a bubble.
- Counters:
  - Saturate at 2^CNT_W-1 and never wrap.
  - cnt_clr zeroes both counters and overrides any increment in the same cycle.
  - Counters are unaffected by payload behaviour otherwise.
- in_valid=0 with no flush: the payload is still loaded, and out_valid=0 marks the slot as empty.
- Reset asserted mid-stall or mid-flush: outputs go to 0 immediately, without waiting for a clock edge.
- Reset deassertion: the first edge after deassertion behaves as a normal edge.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package pipe_pkg holds:
  - W_WORD=32
  - NOP_INSTR=32'h0000_0000
  - channel index constants CH_PC=0, CH_IR=1, CH_RS=2, CH_RT=3, CH_EXT=4
  - CNT_W_DEFAULT=16
- Sub-module sat_counter (CNT_W, inc, clr, count) is instantiated twice, once for stall_cnt and once for bubble_cnt.
- The payload register is a generate loop over NCH channels with a per-channel flush mux that special-cases PC_IDX.

Test Plan:
1. Reset and load: rst_n=0 then 1, in_valid=1, PC=0x0000_3000, IR=0x2408_0005, one edge -> out_valid=1, PC=0x3000, IR=0x24080005, counters 0.
2. Stall hold: load PC=0x3004, then stall=1 for 3 cycles while in_data changes to PC=0x3008 -> outputs stay at PC=0x3004; stall_cnt=3, bubble_cnt=0.
3. Flush with stall and PC keep: stall=1, flush=1, in PC=0x3010, in_bd=1, IR=0x1000_0003 -> out_valid=0, IR=0, PC=0x3010, out_bd=1, other channels 0, bubble_cnt=1, stall_cnt unchanged.
4. Same as 3 with KEEP_PC_ON_FLUSH=0 -> PC=0, out_bd=0, out_valid=0.
5. Saturation and clear: CNT_W=2, stall 5 cycles on a valid entry -> stall_cnt=3; then cnt_clr=1 together with stall=1 -> stall_cnt=0.
6. Asynchronous reset mid-stall: stall=1 with out_valid=1 and PC=0x3020, drop rst_n between edges -> all outputs 0 before the next edge; release rst_n and load PC=0x3024 -> out PC=0x3024 after one edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the MIPS inter-stage pipeline registers.
// Gives the channel layout, the NOP encoding and the per-edge operation decode.
package pipe_pkg;

    localparam int W_WORD        = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam int CH_PC  = 0;
    localparam int CH_IR  = 1;
    localparam int CH_RS  = 2;
    localparam int CH_RT  = 3;
    localparam int CH_EXT = 4;

    localparam int CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'd0,
        OP_HOLD  = 2'd1,
        OP_FLUSH = 2'd2
    } stage_op_e;

    // Flush beats stall beats load.
    function automatic stage_op_e decode_op(input logic flush, input logic stall);
        if (flush)
            return OP_FLUSH;
        if (stall)
            return OP_HOLD;
        return OP_LOAD;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating event counter with synchronous clear; clear overrides increment.
// Used for the stall and bubble statistics of a pipeline stage register.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v)
            return v;
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic [CNT_W-1:0] cnt_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_p1 <= '0;
        else if (clr)
            cnt_p1 <= '0;
        else if (inc)
            cnt_p1 <= sat_inc(cnt_p1);
    end

    assign count = cnt_p1;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register (F/D, D/E, E/M, M/W) with stall, flush-to-bubble
// and saturating stall/bubble counters for the hazard-debug path.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int NCH              = 5,
    parameter int W                = W_WORD,
    parameter int PC_IDX           = CH_PC,
    parameter int IR_IDX           = CH_IR,
    parameter int KEEP_PC_ON_FLUSH = 1,
    parameter int CNT_W            = CNT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [NCH*W-1:0]   in_data,
    input  logic               in_bd,
    input  logic               stall,
    input  logic               flush,
    input  logic               cnt_clr,
    output logic               out_valid,
    output logic [NCH*W-1:0]   out_data,
    output logic               out_bd,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   bubble_cnt
);

    localparam bit KEEP_PC = (KEEP_PC_ON_FLUSH != 0);

    stage_op_e        op;
    logic             vld_p1;
    logic             bd_p1;
    logic [W-1:0]     data_p1 [NCH];
    logic             stall_inc;
    logic             bubble_inc;

    always_comb begin
        op = decode_op(flush, stall);
    end

    // ---- p0 -> p1 : payload channels, each with its own bubble value
    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [W-1:0] in_ch;
        logic [W-1:0] bubble_ch;

        assign in_ch = in_data[k*W +: W];

        if (k == PC_IDX && KEEP_PC) begin : g_keep_pc
            // EPC must see the faulting PC even though the slot is a bubble.
            assign bubble_ch = in_ch;
        end else if (k == IR_IDX) begin : g_nop
            assign bubble_ch = W'(NOP_INSTR);
        end else begin : g_zero
            assign bubble_ch = '0;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_p1[k] <= '0;
            end else begin
                case (op)
                    OP_LOAD:  data_p1[k] <= in_ch;
                    OP_FLUSH: data_p1[k] <= bubble_ch;
                    default:  data_p1[k] <= data_p1[k];
                endcase
            end
        end

        assign out_data[k*W +: W] = data_p1[k];
    end

    // ---- p0 -> p1 : valid and delay-slot flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            bd_p1  <= 1'b0;
        end else begin
            case (op)
                OP_LOAD: begin
                    vld_p1 <= in_valid;
                    bd_p1  <= in_bd;
                end
                OP_FLUSH: begin
                    vld_p1 <= 1'b0;
                    bd_p1  <= KEEP_PC ? in_bd : 1'b0;
                end
                default: begin
                    vld_p1 <= vld_p1;
                    bd_p1  <= bd_p1;
                end
            endcase
        end
    end

    assign out_valid = vld_p1;
    assign out_bd    = bd_p1;

    // Only a stall that actually freezes a live instruction counts as lost work.
    assign stall_inc  = (op == OP_HOLD) && vld_p1;
    assign bubble_inc = (op == OP_FLUSH);

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .clr   (cnt_clr),
        .count (stall_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bubble_inc),
        .clr   (cnt_clr),
        .count (bubble_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (default, no PC keep, 2-bit counters)
// share one stimulus; a behavioural model feeds a scoreboard queue.
module tb_pipe_stage_reg;

    localparam int NCH = 5;
    localparam int W   = 32;
    localparam int DW  = NCH * W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_bd;
    logic          stall;
    logic          flush;
    logic          cnt_clr;

    logic          a_valid, n_valid, c_valid;
    logic [DW-1:0] a_data, n_data, c_data;
    logic          a_bd, n_bd, c_bd;
    logic [15:0]   a_sc, a_bc, n_sc, n_bc;
    logic [1:0]    c_sc, c_bc;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic          v;
        logic          bd;
        logic [DW-1:0] d;
        int            sc;
        int            bc;
    } st_t;

    typedef struct {
        st_t a;
        st_t n;
        st_t c;
    } exp_t;

    st_t  m_a, m_n, m_c;
    exp_t sbq [$];

    always #5 clk = ~clk;

    pipe_stage_reg u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_bd(in_bd),
        .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .out_valid(a_valid), .out_data(a_data), .out_bd(a_bd),
        .stall_cnt(a_sc), .bubble_cnt(a_bc)
    );

    pipe_stage_reg #(.KEEP_PC_ON_FLUSH(0)) u_nokeep (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_bd(in_bd),
        .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .out_valid(n_valid), .out_data(n_data), .out_bd(n_bd),
        .stall_cnt(n_sc), .bubble_cnt(n_bc)
    );

    pipe_stage_reg #(.CNT_W(2)) u_cnt2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_bd(in_bd),
        .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .out_valid(c_valid), .out_data(c_data), .out_bd(c_bd),
        .stall_cnt(c_sc), .bubble_cnt(c_bc)
    );

    function automatic logic [DW-1:0] mk(input logic [31:0] pc, input logic [31:0] ir,
                                         input logic [31:0] rs, input logic [31:0] rt,
                                         input logic [31:0] ext);
        return {ext, rt, rs, ir, pc};
    endfunction

    function automatic st_t zero_st();
        st_t r;
        r.v = 1'b0; r.bd = 1'b0; r.d = '0; r.sc = 0; r.bc = 0;
        return r;
    endfunction

    // Reference next-state for one instance, from the current TB inputs.
    function automatic st_t nxt(input st_t s, input bit keep, input int cmax);
        st_t r = s;
        if (flush) begin
            r.v = 1'b0;
            r.d = '0;
            if (keep) begin
                r.d[31:0] = in_data[31:0];
                r.bd      = in_bd;
            end else begin
                r.bd = 1'b0;
            end
        end else if (!stall) begin
            r.v  = in_valid;
            r.d  = in_data;
            r.bd = in_bd;
        end
        if (cnt_clr) begin
            r.sc = 0;
            r.bc = 0;
        end else begin
            if (!flush && stall && s.v && s.sc < cmax) r.sc = s.sc + 1;
            if (flush && s.bc < cmax)                  r.bc = s.bc + 1;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_inst(input string nm, input st_t e, input logic v, input logic bd,
                            input logic [DW-1:0] d, input logic [15:0] sc, input logic [15:0] bc);
        chk({nm, ".valid"},  DW'(v),  DW'(e.v));
        chk({nm, ".bd"},     DW'(bd), DW'(e.bd));
        chk({nm, ".data"},   d,       e.d);
        chk({nm, ".stall"},  DW'(sc), DW'(e.sc));
        chk({nm, ".bubble"}, DW'(bc), DW'(e.bc));
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk_inst({tag, ":a"}, e.a, a_valid, a_bd, a_data, a_sc, a_bc);
        chk_inst({tag, ":n"}, e.n, n_valid, n_bd, n_data, n_sc, n_bc);
        chk_inst({tag, ":c"}, e.c, c_valid, c_bd, c_data, {14'b0, c_sc}, {14'b0, c_bc});
    endtask

    task automatic step(input string tag);
        exp_t e;
        m_a = nxt(m_a, 1'b1, 65535);
        m_n = nxt(m_n, 1'b0, 65535);
        m_c = nxt(m_c, 1'b1, 3);
        sbq.push_back('{a: m_a, n: m_n, c: m_c});
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
        end else begin
            e = sbq.pop_front();
            chk_all(tag, e);
        end
    endtask

    task automatic do_reset_check(input string tag);
        m_a = zero_st();
        m_n = zero_st();
        m_c = zero_st();
        sbq.delete();
        chk_all(tag, '{a: m_a, n: m_n, c: m_c});
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_bd    = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        cnt_clr  = 1'b0;
        #12;
        do_reset_check("reset");
        rst_n = 1'b1;

        // Reset and load
        in_valid = 1'b1;
        in_data  = mk(32'h0000_3000, 32'h2408_0005, 32'h11, 32'h22, 32'h5);
        step("load1");

        // Stall hold over changing input
        in_data = mk(32'h0000_3004, 32'h2409_0006, 32'h33, 32'h44, 32'h6);
        step("load2");
        stall   = 1'b1;
        in_data = mk(32'h0000_3008, 32'hDEAD_BEEF, 32'h55, 32'h66, 32'h7);
        for (int i = 0; i < 3; i++) step("stall_hold");

        // Flush while stalled, delay-slot instruction
        flush   = 1'b1;
        in_bd   = 1'b1;
        in_data = mk(32'h0000_3010, 32'h1000_0003, 32'h77, 32'h88, 32'h9);
        step("flush_stall");

        // Empty slot still loads payload
        flush    = 1'b0;
        stall    = 1'b0;
        in_bd    = 1'b0;
        in_valid = 1'b0;
        in_data  = mk(32'h0000_3014, 32'h0123_4567, 32'h1, 32'h2, 32'h3);
        step("load_invalid");
        stall = 1'b1;
        step("stall_invalid");

        // Saturation then clear-with-stall
        stall    = 1'b0;
        in_valid = 1'b1;
        cnt_clr  = 1'b1;
        in_data  = mk(32'h0000_3018, 32'h2408_0001, 32'h0, 32'h0, 32'h0);
        step("clr_load");
        cnt_clr = 1'b0;
        stall   = 1'b1;
        for (int i = 0; i < 5; i++) step("stall_sat");
        flush = 1'b1;
        for (int i = 0; i < 5; i++) step("bubble_sat");
        flush   = 1'b0;
        cnt_clr = 1'b1;
        step("clr_stall");
        cnt_clr = 1'b0;

        // Asynchronous reset between edges while stalled
        stall   = 1'b0;
        in_data = mk(32'h0000_3020, 32'h2408_0002, 32'hA, 32'hB, 32'hC);
        step("load_3020");
        stall = 1'b1;
        step("stall_3020");
        #2;
        rst_n = 1'b0;
        #1;
        do_reset_check("async_reset");
        rst_n   = 1'b1;
        stall   = 1'b0;
        in_data = mk(32'h0000_3024, 32'h2408_0003, 32'hD, 32'hE, 32'hF);
        step("load_3024");

        // Mixed random traffic
        for (int i = 0; i < 40; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_bd    = 1'($urandom_range(0, 1));
            stall    = ($urandom_range(0, 3) == 0);
            flush    = ($urandom_range(0, 5) == 0);
            cnt_clr  = ($urandom_range(0, 15) == 0);
            in_data  = mk($urandom, $urandom, $urandom, $urandom, $urandom);
            step("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
